pong_logo_text: RTL
===================

Name: pong_logo_text

Overview:
Pixel-stream renderer for the "PONG" title logo. It converts the current VGA pixel coordinate into a glyph address for the registered-address font ROM (1-cycle read latency), consumes the returned 8-bit glyph row, and produces a pipelined logo pixel plus colour. A frame-synchronous state machine shows the logo steadily, then blinks it with cycling colour, all gated by logo_en. It sits between vga_sync and the pixel colour mux.

Parameters:
SCALE_LOG2, 3, each font pixel drawn as 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels (default glyph is 64x128).
LOGO_X0, 192, left edge of the logo in pixels (logo spans 4 glyphs horizontally).
LOGO_Y0, 64, top edge of the logo in pixels.
HOLD_FRAMES, 120, frames of steady display before blinking starts (>=1).
BLINK_FRAMES, 30, frames per blink half-period (>=1).

Ports:
clk  in  1  system clock, one pixel per cycle
reset  in  1  synchronous, active-high
video_on  in  1  visible-area flag, aligned with pixel_x/pixel_y
pixel_x  in  10  current column
pixel_y  in  10  current row
frame_tick  in  1  1-cycle pulse per frame, asserted during vertical blank
logo_en  in  1  request to display the logo, level-sensitive
rom_addr  out  11  font ROM address {char_code[6:0], glyph_row[3:0]}, combinational
rom_data  in  8  font ROM row, valid one clock after rom_addr
logo_on  out  1  logo pixel active, registered
logo_rgb  out  3  logo colour, registered, 3'b000 whenever logo_on=0

Behaviour:
- Geometry: rel_x = pixel_x - LOGO_X0; rel_y = pixel_y - LOGO_Y0 (10-bit).
- in_region = pixel_x>=LOGO_X0 and rel_x < 32<<SCALE_LOG2 and pixel_y>=LOGO_Y0 and rel_y < 16<<SCALE_LOG2.
- char_idx = rel_x[SCALE_LOG2+4:SCALE_LOG2+3]; bit_col = rel_x[SCALE_LOG2+2:SCALE_LOG2]; glyph_row = rel_y[SCALE_LOG2+3:SCALE_LOG2].
- Character codes by char_idx: 0 maps to 7'h50 'P', 1 to 7'h4F 'O', 2 to 7'h4E 'N', 3 to 7'h47 'G'.
- rom_addr = {code, glyph_row} when in_region, else 11'h000.
- Pipeline: at edge N the block registers in_region, bit_col and video_on into stage 1, which is aligned with rom_data. In cycle N+1, pix = rom_data[7-bit_col_d]. At edge N+1 it registers logo_on = pix & in_region_d & video_on_d & visible, and logo_rgb = logo_on ? rgb : 0. Total latency is 2 clocks from pixel_x/pixel_y to logo_on. Upstream must delay hsync/vsync by 2 clocks.
- FSM states are IDLE, SHOW and BLINK. Only a frame_tick edge can change state, visible, cnt or rgb, so there is no mid-frame tearing.
- IDLE: visible=0. On frame_tick with logo_en=1, go to SHOW with visible=1, cnt=0, rgb=3'b111.
- SHOW, on frame_tick:
  - logo_en=0: go to IDLE, visible=0.
  - else if cnt==HOLD_FRAMES-1: go to BLINK, cnt=0, visible=0.
  - else cnt++.
- BLINK, on frame_tick:
  - logo_en=0: go to IDLE, visible=0.
  - else if cnt==BLINK_FRAMES-1: cnt=0, visible toggles. On a 0->1 toggle, rgb advances 7->1 or else rgb+1, so it never reaches 0.
  - else cnt++.
- logo_en changes between frame_ticks are ignored until the next frame_tick.
- cnt is 8 bits. Parameters up to 256 are legal; the counter must not wrap before the terminal compare.
- Reset: state=IDLE, visible=0, cnt=0, rgb=3'b111, pipeline registers 0, logo_on=0, logo_rgb=0. Reset mid-frame or mid-blink returns to IDLE in the next cycle. The pixel pipeline outputs 0 for the 2 cycles after reset.
- Pixels at x=LOGO_X0-1 and x=LOGO_X0+256 (defaults) are out of region: rom_addr=0 and logo_on=0.

Test Plan:
1. Reset, then logo_en=1 and one frame_tick. Drive pixel (192,80) with video_on=1 -> rom_addr=11'h502 the same cycle; logo_on=1 and logo_rgb=3'b111 two clocks later ('P' row 2 = 11111100, col 0).
2. SHOW state, pixel (240,80) -> rom_addr=11'h502, logo_on=0 (col 6). Pixel (400,80) -> rom_addr=11'h472, logo_on=1 ('G' col 2). Pixel (384,80) -> logo_on=0.
3. Pixel (191,80) and pixel (448,80) -> rom_addr=11'h000 and logo_on=0. The same in-region pixel with video_on=0 -> logo_on=0.
4. HOLD_FRAMES=2, BLINK_FRAMES=2, logo_en held high, frame_ticks counted:
   - tick 1: SHOW, visible.
   - tick 3: BLINK, hidden.
   - tick 5: visible, rgb=3'b001.
   - tick 7: hidden.
   - tick 9: visible, rgb=3'b010.
5. Drop logo_en mid-frame in BLINK -> visible unchanged until the next frame_tick, then IDLE with logo_on=0. Re-raise logo_en and tick -> SHOW with rgb=3'b111.
6. Assert reset for 1 cycle while streaming visible logo pixels -> logo_on=0 for the next 2 cycles and FSM=IDLE. Without a frame_tick, the logo stays off even with logo_en=1.

Source files
------------

// File: rtl/pong_logo_text.sv
// rtl/pong_logo_text.sv - PONG title logo renderer: glyph addressing, 2-stage pixel pipeline, frame-synchronous show/blink FSM
module pong_logo_text #(
    parameter int SCALE_LOG2   = 3,
    parameter int LOGO_X0      = 192,
    parameter int LOGO_Y0      = 64,
    parameter int HOLD_FRAMES  = 120,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        frame_tick,
    input  logic        logo_en,
    output logic [10:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        logo_on,
    output logic [2:0]  logo_rgb
);

    localparam logic [9:0]  X0         = 10'(LOGO_X0);
    localparam logic [9:0]  Y0         = 10'(LOGO_Y0);
    // Widths are 11 bits so a large SCALE_LOG2 cannot truncate the extent to zero
    localparam logic [10:0] W_EXTENT   = 11'(32 << SCALE_LOG2);
    localparam logic [10:0] H_EXTENT   = 11'(16 << SCALE_LOG2);
    // Terminal counts of 256 map to 8'hFF, so the 8-bit counter never wraps first
    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLINK = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_visible, w_visible_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [2:0]  r_rgb, w_rgb_nxt;

    logic [9:0]  w_rel_x, w_rel_y;
    logic        w_in_region;
    logic [1:0]  w_char_idx;
    logic [2:0]  w_bit_col;
    logic [3:0]  w_glyph_row;
    logic [6:0]  w_code;

    logic        r_in_region_d;
    logic [2:0]  r_bit_col_d;
    logic        r_video_on_d;
    logic        w_pix;
    logic        w_logo_on;
    logic        r_logo_on;
    logic [2:0]  r_logo_rgb;

    assign w_rel_x     = pixel_x - X0;
    assign w_rel_y     = pixel_y - Y0;
    assign w_in_region = (pixel_x >= X0) && ({1'b0, w_rel_x} < W_EXTENT) &&
                         (pixel_y >= Y0) && ({1'b0, w_rel_y} < H_EXTENT);
    assign w_char_idx  = w_rel_x[SCALE_LOG2+4 -: 2];
    assign w_bit_col   = w_rel_x[SCALE_LOG2+2 -: 3];
    assign w_glyph_row = w_rel_y[SCALE_LOG2+3 -: 4];

    // Character code lookup for the four logo letters
    always_comb begin
        w_code = 7'h47;
        case (w_char_idx)
            2'd0:    w_code = 7'h50;
            2'd1:    w_code = 7'h4F;
            2'd2:    w_code = 7'h4E;
            default: w_code = 7'h47;
        endcase
    end

    assign rom_addr = w_in_region ? {w_code, w_glyph_row} : 11'h000;

    // FSM and display-attribute registers; all updates come from the comb block below
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_visible <= 1'b0;
            r_cnt     <= 8'd0;
            r_rgb     <= 3'b111;
        end else begin
            r_state   <= w_state_nxt;
            r_visible <= w_visible_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rgb     <= w_rgb_nxt;
        end
    end

    // Next-state logic; nothing moves except on frame_tick so a frame never tears
    always_comb begin
        w_state_nxt   = r_state;
        w_visible_nxt = r_visible;
        w_cnt_nxt     = r_cnt;
        w_rgb_nxt     = r_rgb;
        if (frame_tick) begin
            case (r_state)
                ST_IDLE: begin
                    w_visible_nxt = 1'b0;
                    if (logo_en) begin
                        w_state_nxt   = ST_SHOW;
                        w_visible_nxt = 1'b1;
                        w_cnt_nxt     = 8'd0;
                        w_rgb_nxt     = 3'b111;
                    end
                end
                ST_SHOW: begin
                    if (!logo_en) begin
                        w_state_nxt   = ST_IDLE;
                        w_visible_nxt = 1'b0;
                    end else if (r_cnt == HOLD_LAST) begin
                        w_state_nxt   = ST_BLINK;
                        w_cnt_nxt     = 8'd0;
                        w_visible_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                ST_BLINK: begin
                    if (!logo_en) begin
                        w_state_nxt   = ST_IDLE;
                        w_visible_nxt = 1'b0;
                    end else if (r_cnt == BLINK_LAST) begin
                        w_cnt_nxt     = 8'd0;
                        w_visible_nxt = ~r_visible;
                        // Colour steps on each reappearance, skipping black
                        if (!r_visible)
                            w_rgb_nxt = (r_rgb == 3'b111) ? 3'b001 : r_rgb + 3'b001;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt   = ST_IDLE;
                    w_visible_nxt = 1'b0;
                end
            endcase
        end
    end

    assign w_pix     = rom_data[3'd7 - r_bit_col_d];
    assign w_logo_on = w_pix & r_in_region_d & r_video_on_d & r_visible;

    // Pixel pipeline: stage 1 aligns with rom_data, stage 2 is the registered output
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_region_d <= 1'b0;
            r_bit_col_d   <= 3'd0;
            r_video_on_d  <= 1'b0;
            r_logo_on     <= 1'b0;
            r_logo_rgb    <= 3'b000;
        end else begin
            r_in_region_d <= w_in_region;
            r_bit_col_d   <= w_bit_col;
            r_video_on_d  <= video_on;
            r_logo_on     <= w_logo_on;
            r_logo_rgb    <= w_logo_on ? r_rgb : 3'b000;
        end
    end

    assign logo_on  = r_logo_on;
    assign logo_rgb = r_logo_rgb;

endmodule
